// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control path: state codes, opcodes,
// datapath select values and the bundle of control strobes.
package mips_ctrl_pkg;

  // Controller state codes (4-bit, codes 11..15 unused)
  localparam logic [3:0] ST_RST      = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR = 4'd3;
  localparam logic [3:0] ST_MEM_RD   = 4'd4;
  localparam logic [3:0] ST_MEM_WB   = 4'd5;
  localparam logic [3:0] ST_MEM_WR   = 4'd6;
  localparam logic [3:0] ST_EXEC     = 4'd7;
  localparam logic [3:0] ST_R_WB     = 4'd8;
  localparam logic [3:0] ST_ADDI_WB  = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;

  // Supported opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Branch condition select used by the datapath PC-load qualifier
  localparam logic [1:0] BROP_NONE = 2'b00;
  localparam logic [1:0] BROP_BEQ  = 2'b01;
  localparam logic [1:0] BROP_BNE  = 2'b10;

  // All control strobes and selects driven toward the datapath
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] branch_op;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       instr_done;
  } ctrl_t;

  // True for opcodes the controller executes; anything else retires as a NOP
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ)  || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle controller and the datapath.
// The controller is the master: it reads opcode/mem_ready and drives
// every select and enable.
interface multicycle_control_if;

  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] BranchOp;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       PCSource;
  logic       instr_done;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, BranchOp, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, BranchOp, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done
  );

endinterface

// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multi-cycle MIPS datapath. Walks each
// instruction through FETCH, DECODE and its class-specific states, and
// decodes every datapath control from the current state (plus mem_ready
// and opcode where a strobe must be qualified in the same cycle).
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input logic               clk,
  input logic               reset,
  multicycle_control_if.master bus
);

  logic [3:0] state;
  logic [3:0] next_state;
  ctrl_t      ctrl;

  // State register; reset drops straight to RST so all strobes fall at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RST;
    else       state <= next_state;
  end

  // Next-state selection; memory states wait on mem_ready, unused codes recover via RST
  always_comb begin
    next_state = ST_RST;
    case (state)
      ST_RST:      next_state = ST_FETCH;
      ST_FETCH:    next_state = bus.mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:      next_state = ST_MEM_ADDR;
          OP_RTYPE, OP_ADDI: next_state = ST_EXEC;
          OP_BEQ, OP_BNE:    next_state = ST_BRANCH;
          default:           next_state = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: next_state = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   next_state = bus.mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:   next_state = ST_FETCH;
      ST_MEM_WR:   next_state = bus.mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_EXEC:     next_state = (bus.opcode == OP_RTYPE) ? ST_R_WB : ST_ADDI_WB;
      ST_R_WB:     next_state = ST_FETCH;
      ST_ADDI_WB:  next_state = ST_FETCH;
      ST_BRANCH:   next_state = ST_FETCH;
      default:     next_state = ST_RST;
    endcase
  end

  // Output decode; every control not named for a state stays at zero
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = bus.mem_ready;
        ctrl.ir_write  = bus.mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.instr_done = !op_supported(bus.opcode);
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = bus.mem_ready;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        if (bus.opcode == OP_RTYPE) begin
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = ALUOP_FUNCT;
        end else begin
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
      end
      ST_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.branch_op     = (bus.opcode == OP_BNE) ? BROP_BNE : BROP_BEQ;
        ctrl.instr_done    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.BranchOp    = ctrl.branch_op;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.instr_done  = ctrl.instr_done;

endmodule
